// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: one voice is accumulated per clock,
// then the sum is scaled, saturated and re-centred as offset binary.
module voice_mixer #(
  parameter int NUM_VOICES  = 4,
  parameter int VOICE_BITS  = 12,
  parameter int GAIN_BITS   = 4,
  parameter int OUTPUT_BITS = 12
) (
  input  logic                             main_clk,
  input  logic                             rst,
  input  logic                             sample_tick,
  input  logic [NUM_VOICES*VOICE_BITS-1:0] voice_din,
  input  logic [NUM_VOICES*GAIN_BITS-1:0]  voice_gain,
  output logic [OUTPUT_BITS-1:0]           dout,
  output logic                             dout_valid,
  output logic                             clip,
  output logic                             busy,
  output logic                             overrun
);

  localparam int NV = NUM_VOICES;
  localparam int VB = VOICE_BITS;
  localparam int GB = GAIN_BITS;
  localparam int OB = OUTPUT_BITS;
  localparam int IW = (NV > 1) ? $clog2(NV) : 1;
  localparam int AW = VB + GB + $clog2(NV) + 1;
  localparam int SH = GB + VB - OB;

  localparam logic signed [AW-1:0] SMAX = AW'((1 << (OB-1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic [IW-1:0] LAST = IW'(NV - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state_q, state_d;
  logic [VB-1:0] snap_din_q [NV];
  logic [GB-1:0] snap_gain_q [NV];
  logic [IW-1:0] idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [OB-1:0] dout_q, dout_d;
  logic valid_q, valid_d;
  logic clip_q, clip_d;
  logic ovr_q, ovr_d;
  logic load;

  logic [VB-1:0] cur_din;
  logic [GB-1:0] cur_gain;
  logic signed [VB:0] diff;
  logic signed [AW-1:0] diff_x, gain_x, term;
  logic signed [AW-1:0] shifted;
  logic signed [OB-1:0] sat;
  logic sat_hit;

  assign cur_din  = snap_din_q[idx_q];
  assign cur_gain = snap_gain_q[idx_q];
  // Re-centre around the midpoint so silence contributes nothing.
  assign diff   = $signed({1'b0, cur_din})
                - $signed({2'b01, {(VB-1){1'b0}}});
  assign diff_x = AW'(diff);
  assign gain_x = AW'($signed({1'b0, cur_gain}));
  assign term   = diff_x * gain_x;

  assign shifted = acc_q >>> SH;

  always_comb begin
    sat     = shifted[OB-1:0];
    sat_hit = 1'b0;
    if (shifted > SMAX) begin
      sat     = {1'b0, {(OB-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < SMIN) begin
      sat     = {1'b1, {(OB-1){1'b0}}};
      sat_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    clip_d  = clip_q;
    valid_d = 1'b0;
    load    = 1'b0;
    ovr_d   = ovr_q | (sample_tick & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          load    = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + term;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        dout_d  = {~sat[OB-1], sat[OB-2:0]};
        clip_d  = sat_hit;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      dout_q  <= {1'b1, {(OB-1){1'b0}}};
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
    end
  end

  // Snapshot so input changes mid-mix cannot disturb the result.
  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NV; i++) begin
        snap_din_q[i]  <= '0;
        snap_gain_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NV; i++) begin
        snap_din_q[i]  <= voice_din[i*VB +: VB];
        snap_gain_q[i] <= voice_gain[i*GB +: GB];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign clip       = clip_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = ovr_q;

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Downstream consumer of the per-voice outputs. Sums the 12-bit unsigned `dout` of NUM_VOICES voices into one mixed sample, with a per-voice gain on each voice.
- The sum is saturated and emitted as a single unsigned, offset-binary sample per sample tick, ready for the DAC/PWM output stage.
- The block is time-multiplexed: one voice is accumulated per main_clk cycle, which avoids an N-input adder tree.

Parameters:
- NUM_VOICES, 4: number of voice inputs (1..16).
- VOICE_BITS, 12: width of each voice sample, unsigned, midpoint 2^(VOICE_BITS-1) = silence.
- GAIN_BITS, 4: per-voice gain width. Effective gain is g/2^GAIN_BITS (0..15/16).
- OUTPUT_BITS, 12: mixed output width (8..VOICE_BITS).

Ports:
- main_clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- sample_tick  in  1  single-cycle strobe in the main_clk domain; starts one mix.
- voice_din  in  NUM_VOICES*VOICE_BITS  packed voice samples; voice i occupies bits [i*VOICE_BITS +: VOICE_BITS].
- voice_gain  in  NUM_VOICES*GAIN_BITS  packed per-voice gains, same packing.
- dout  out  OUTPUT_BITS  mixed sample, unsigned offset-binary.
- dout_valid  out  1  one-cycle pulse when dout updates.
- clip  out  1  high if the current dout was saturated.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  sticky; set when a tick is dropped.

Behaviour:
- FSM states: IDLE, ACCUM, DONE. busy = (state != IDLE).
- Reset (rst=0, asynchronous): state=IDLE, acc=0, idx=0, dout=2^(OUTPUT_BITS-1), dout_valid=0, clip=0, overrun=0, busy=0. Any mix in flight is abandoned; no dout_valid follows.
- IDLE, sample_tick=1 at edge T:
  - snapshot all voice_din and voice_gain into internal registers;
  - set acc=0, idx=0;
  - go to ACCUM.
  - Later input changes do not affect this mix.
- ACCUM, one edge per voice (edges T+1..T+NUM_VOICES):
  - term = (snap_din[idx] - 2^(VOICE_BITS-1)), as signed VOICE_BITS+1, multiplied by unsigned snap_gain[idx];
  - acc += term; idx++;
  - after idx=NUM_VOICES-1, go to DONE.
  - Width of acc: VOICE_BITS+GAIN_BITS+clog2(NUM_VOICES)+1 signed. It never wraps.
- DONE, edge T+NUM_VOICES+1:
  - s = acc >>> (GAIN_BITS + VOICE_BITS - OUTPUT_BITS), arithmetic shift, floor rounding;
  - saturate s to [-2^(OUTPUT_BITS-1), 2^(OUTPUT_BITS-1)-1];
  - dout = saturated s + 2^(OUTPUT_BITS-1);
  - clip = 1 if saturation occurred, else 0;
  - dout_valid = 1 for exactly one cycle;
  - go to IDLE.
- Latency: dout/dout_valid are visible in the cycle after edge T+NUM_VOICES+1, i.e. NUM_VOICES+2 cycles after the tick is sampled.
- dout and clip hold their values between updates.
- sample_tick while busy (ACCUM or DONE): the tick is ignored and overrun is set to 1. overrun clears only on reset.
- sample_tick in the cycle dout_valid is high: state is IDLE, so the tick is accepted normally.
- sample_tick held high continuously: a new mix starts every NUM_VOICES+2 cycles; the intermediate ticks set overrun.
- Gain 0 fully mutes that voice.
- A voice at midpoint contributes 0 regardless of its gain.

Test Plan (defaults: NUM_VOICES=4, VOICE_BITS=12, GAIN_BITS=4, OUTPUT_BITS=12):
- Reset: assert rst=0 asynchronously mid-cycle -> dout=2048, dout_valid=0, busy=0, clip=0, overrun=0 immediately, without waiting for a clock edge.
- Single voice: voice0=3072 gain 8, others 2048 gain 15, tick at T -> busy for cycles T+1..T+5, dout=2560, dout_valid high only in cycle T+6, clip=0.
- Rounding: voice0=2047 gain 1, others 2048 -> dout=2047. Voice0=2049 gain 1 -> dout=2048.
- Saturation: all voices 4095 gain 15 -> dout=4095, clip=1. All voices 0 gain 15 -> dout=0, clip=1. Next mix with all voices 2048 -> dout=2048, clip=0.
- Snapshot and overrun:
  - tick at T with voice0=3072 gain 8; change voice0 to 0 at T+2 -> result still 2560;
  - second tick at T+3 -> no extra dout_valid, overrun=1 and stays 1;
  - tick in the valid cycle T+6 -> accepted, next dout_valid at T+12.
- Reset mid-mix: tick at T, rst=0 at T+3 for 2 cycles -> dout=2048, no dout_valid pulse. A fresh tick after release produces a correct mix with the expected latency.
